// File: rtl/clken_gen_multi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clken_gen_multi
//
// Multi-channel fractional clock-enable generator. Every channel owns a
// phase accumulator (NCO). The accumulator advances by that channel's
// increment on each refclk edge. A wrap of the accumulator produces a
// single-cycle strobe on ce_out, one cycle after the wrapping edge. The
// strobe rate is therefore f_refclk * inc / 2^ACC_W.
//
// Rate changes are glitch-free. A new increment is first held as a pending
// update. It is swapped in only on the edge where the channel's accumulator
// wraps, so a strobe period is never shortened or stretched mid-period.
// A channel that cannot wrap (inc == 0, or generator stopped) takes the
// update on the very next edge instead.
//
// 'locked' qualifies the strobes. It is high once the generator has run
// with a settled configuration for LOCK_CYCLES consecutive cycles.
//
// Optional feature, macro CLKEN_GEN_PHASE_EN:
//   When defined, adds the cfg_phase port and one phase register per
//   channel. While enable is low each accumulator is preloaded with its
//   phase, so channels restart with deterministic phase offsets.
//   When undefined, every accumulator restarts from zero.
//
// Parameters:
//   NUM_CH      number of enable channels (1..16)
//   ACC_W       accumulator / increment width in bits (8..48)
//   LOCK_CYCLES settled cycles required before locked rises (1..65535)
//
// Ports:
//   refclk     in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   global run; low stops and clears all accumulators
//   cfg_valid  in   configuration write request
//   cfg_ready  out  write accepted when cfg_valid && cfg_ready
//   cfg_ch     in   target channel; out-of-range values are accepted, ignored
//   cfg_inc    in   new increment for the target channel
//   cfg_phase  in   start phase for the target channel (macro only)
//   ce_out     out  per-channel single-cycle enable strobes
//   locked     out  strobes stable and configuration settled
// ---------------------------------------------------------------------------
module clken_gen_multi #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                                          refclk,
  input  logic                                          rst_n,
  input  logic                                          enable,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]                              cfg_inc,
`ifdef CLKEN_GEN_PHASE_EN
  input  logic [ACC_W-1:0]                              cfg_phase,
`endif
  output logic [NUM_CH-1:0]                             ce_out,
  output logic                                          locked
);

  localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] LOCK_THRESH = 16'(LOCK_CYCLES);
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  // Per-channel state
  logic [ACC_W-1:0]  acc_q     [NUM_CH];
  logic [ACC_W-1:0]  acc_d     [NUM_CH];
  logic [ACC_W-1:0]  inc_q     [NUM_CH];
  logic [ACC_W-1:0]  inc_d     [NUM_CH];
  logic [ACC_W-1:0]  pendInc_q [NUM_CH];
  logic [ACC_W-1:0]  pendInc_d [NUM_CH];
  logic [NUM_CH-1:0] pendV_q;
  logic [NUM_CH-1:0] pendV_d;
  logic [NUM_CH-1:0] ce_q;
  logic [NUM_CH-1:0] ce_d;
`ifdef CLKEN_GEN_PHASE_EN
  logic [ACC_W-1:0]  phase_q   [NUM_CH];
  logic [ACC_W-1:0]  phase_d   [NUM_CH];
`endif

  // Lock tracking
  logic [15:0] lockCnt_q;
  logic [15:0] lockCnt_d;
  logic        locked_q;
  logic        locked_d;

  // Combinational helpers
  logic [NUM_CH-1:0] chSel;
  logic              cfgAccept;
  logic              lockClear;
  logic [ACC_W:0]    sum      [NUM_CH];
  logic [ACC_W-1:0]  startVal [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] applyUpd;

  // One-hot decode of the configuration target. An out-of-range cfg_ch
  // selects nothing, which makes it always ready and its write a no-op.
  always_comb begin
    chSel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chSel[i] = (cfg_ch == CH_W'(i));
    end
  end

  // A channel refuses a new write while its previous one is still pending,
  // so an accept and an application never collide on one channel.
  assign cfg_ready = ~|(chSel & pendV_q);
  assign cfgAccept = cfg_valid & cfg_ready;

  // Restart value of each accumulator while stopped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef CLKEN_GEN_PHASE_EN
      startVal[i] = phase_q[i];
`else
      startVal[i] = '0;
`endif
    end
  end

  // Accumulator datapath and pending-update bookkeeping.
  // The wrapping edge still uses the old increment; the new one takes over
  // from the following edge. A channel that can never wrap (inc == 0) or a
  // stopped generator takes the update immediately.
  always_comb begin
    carry    = '0;
    applyUpd = '0;
    pendV_d  = pendV_q;
    ce_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]       = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry[i]     = sum[i][ACC_W];
      acc_d[i]     = enable ? sum[i][ACC_W-1:0] : startVal[i];
      ce_d[i]      = enable & carry[i];
      applyUpd[i]  = pendV_q[i] & (carry[i] | ~enable | (inc_q[i] == '0));
      inc_d[i]     = applyUpd[i] ? pendInc_q[i] : inc_q[i];
      pendInc_d[i] = pendInc_q[i];
      if (applyUpd[i]) begin
        pendV_d[i] = 1'b0;
      end
`ifdef CLKEN_GEN_PHASE_EN
      phase_d[i] = phase_q[i];
`endif
      if (cfgAccept && chSel[i]) begin
        pendInc_d[i] = cfg_inc;
        pendV_d[i]   = 1'b1;
`ifdef CLKEN_GEN_PHASE_EN
        phase_d[i]   = cfg_phase;
`endif
      end
    end
  end

  // Lock counter: restarts on anything that disturbs the strobe pattern
  // (stop, outstanding update, new write) and saturates otherwise. The
  // clearing term also gates locked_d so locked drops on the very next edge
  // rather than one edge later.
  always_comb begin
    lockClear = ~enable | (|pendV_q) | cfgAccept;
    lockCnt_d = lockCnt_q;
    if (lockClear) begin
      lockCnt_d = '0;
    end else if (lockCnt_q != CNT_MAX) begin
      lockCnt_d = lockCnt_q + 16'd1;
    end
    locked_d = ~lockClear & (lockCnt_q >= LOCK_THRESH);
  end

  // State registers. Reset discards any pending update.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]     <= '0;
        inc_q[i]     <= '0;
        pendInc_q[i] <= '0;
`ifdef CLKEN_GEN_PHASE_EN
        phase_q[i]   <= '0;
`endif
      end
      pendV_q   <= '0;
      ce_q      <= '0;
      lockCnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]     <= acc_d[i];
        inc_q[i]     <= inc_d[i];
        pendInc_q[i] <= pendInc_d[i];
`ifdef CLKEN_GEN_PHASE_EN
        phase_q[i]   <= phase_d[i];
`endif
      end
      pendV_q   <= pendV_d;
      ce_q      <= ce_d;
      lockCnt_q <= lockCnt_d;
      locked_q  <= locked_d;
    end
  end

  assign ce_out = ce_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_clken_gen_multi.sv
`timescale 1ns/1ps
// Testbench for clken_gen_multi. A reference model of the strobe rules
// predicts ce_out/locked for every edge and queues the prediction; a
// monitor pops and compares after each rising edge.
module tb_clken_gen_multi;

  localparam int     NUM_CH      = 3;
  localparam int     ACC_W       = 8;
  localparam int     LOCK_CYCLES = 16;
  localparam int     CH_W        = 2;
  localparam longint MOD         = 64'd1 << ACC_W;
  localparam int     STEP_LIMIT  = 600;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
`ifdef CLKEN_GEN_PHASE_EN
  logic [ACC_W-1:0]  cfg_phase;
`endif
  logic [NUM_CH-1:0] ce_out;
  logic              locked;

  int checks = 0;
  int errors = 0;

  logic [NUM_CH:0] expQ[$];
  bit  countOn    = 1'b0;
  int  ch1Strobes = 0;

  // Reference model state: phase position within a turn, active and
  // pending rates, and how many consecutive settled edges have elapsed.
  longint mAcc     [NUM_CH];
  longint mInc     [NUM_CH];
  longint mPendInc [NUM_CH];
  bit     mPendV   [NUM_CH];
`ifdef CLKEN_GEN_PHASE_EN
  longint mPhase   [NUM_CH];
`endif
  int     mSettled;
  bit     lastAccept;

  clken_gen_multi #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
`ifdef CLKEN_GEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .ce_out    (ce_out),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mAcc[i]     = 0;
      mInc[i]     = 0;
      mPendInc[i] = 0;
      mPendV[i]   = 1'b0;
`ifdef CLKEN_GEN_PHASE_EN
      mPhase[i]   = 0;
`endif
    end
    mSettled = 0;
  endtask

  // Predict the outputs after the coming rising edge from the current
  // stimulus, then advance the model.
  task automatic modelStep();
    bit              accept;
    bit              disturbed;
    bit              lk;
    bit              wrapped;
    logic [NUM_CH-1:0] ce;
    longint          turn;
    longint          oldInc;
    int              ch;
    ce         = '0;
    accept     = 1'b0;
    lastAccept = 1'b0;
    if (!rst_n) begin
      modelReset();
      expQ.push_back('0);
      return;
    end
    ch = int'(cfg_ch);
    if (cfg_valid) begin
      if (ch >= NUM_CH) accept = 1'b1;
      else              accept = !mPendV[ch];
    end
    disturbed = !enable || accept;
    for (int i = 0; i < NUM_CH; i++) disturbed = disturbed || mPendV[i];
    lk = !disturbed && (mSettled >= LOCK_CYCLES);
    if (disturbed)             mSettled = 0;
    else if (mSettled < 65535) mSettled++;
    for (int i = 0; i < NUM_CH; i++) begin
      oldInc  = mInc[i];
      turn    = mAcc[i] + oldInc;
      wrapped = (turn >= MOD);
      if (enable) begin
        mAcc[i] = turn % MOD;
        ce[i]   = wrapped;
      end else begin
`ifdef CLKEN_GEN_PHASE_EN
        mAcc[i] = mPhase[i];
`else
        mAcc[i] = 0;
`endif
      end
      if (mPendV[i] && (!enable || oldInc == 0 || (wrapped && enable))) begin
        mInc[i]   = mPendInc[i];
        mPendV[i] = 1'b0;
      end
    end
    if (accept && ch < NUM_CH) begin
      mPendInc[ch] = longint'(cfg_inc);
      mPendV[ch]   = 1'b1;
`ifdef CLKEN_GEN_PHASE_EN
      mPhase[ch]   = longint'(cfg_phase);
`endif
    end
    lastAccept = accept;
    expQ.push_back({lk, ce});
  endtask

  // Drive one cycle of stimulus (called at a falling edge), check the
  // combinational ready, predict the next edge and move to the next fall.
  task automatic applyStimulus(input bit en, input bit valid, input int ch, input int inc);
    bit expReady;
    enable    = en;
    cfg_valid = valid;
    cfg_ch    = CH_W'(ch);
    cfg_inc   = ACC_W'(inc);
    #1;
    if (ch >= NUM_CH) expReady = 1'b1;
    else              expReady = !mPendV[ch];
    checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, expReady});
    modelStep();
    @(negedge refclk);
  endtask

  task automatic idle(input bit en, input int n);
    for (int k = 0; k < n; k++) applyStimulus(en, 1'b0, 0, 0);
  endtask

  task automatic cfgWrite(input bit en, input int ch, input int inc);
    int tries;
    tries      = 0;
    lastAccept = 1'b0;
    while (!lastAccept && tries < STEP_LIMIT) begin
      applyStimulus(en, 1'b1, ch, inc);
      tries++;
    end
    if (!lastAccept) begin
      checks++;
      errors++;
      $display("[TB] FAIL cfg_accept: ch %0d not accepted within %0d cycles", ch, STEP_LIMIT);
    end
    cfg_valid = 1'b0;
  endtask

  // Monitor: compare the DUT against the oldest queued prediction.
  always @(posedge refclk) begin
    logic [NUM_CH:0] e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("ce_out", {{(32-NUM_CH){1'b0}}, ce_out}, {{(32-NUM_CH){1'b0}}, e[NUM_CH-1:0]});
      checkOutput("locked", {31'd0, locked}, {31'd0, e[NUM_CH]});
      if (countOn && ce_out[1]) ch1Strobes++;
    end
  end

  initial begin
    int r;
    int inc;
    bit en;
    rst_n     = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_inc   = '0;
`ifdef CLKEN_GEN_PHASE_EN
    cfg_phase = '0;
`endif
    modelReset();
    @(negedge refclk);
    @(negedge refclk);
    checkOutput("reset_ce", {29'd0, ce_out}, 32'd0);
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;

    // ch1 at 0xCD for 256 cycles: exactly 205 strobes, ch0 silent.
    idle(1'b1, 2);
    cfgWrite(1'b1, 1, 'hCD);
    idle(1'b1, 1);
    countOn = 1'b1;
    idle(1'b1, 256);
    countOn = 1'b0;
    checkOutput("ch1_strobes_256", ch1Strobes, 32'd205);

    // Stop with strobes active, program ch0 at half rate, restart.
    idle(1'b0, 3);
    cfgWrite(1'b0, 0, 'h80);
    idle(1'b0, 1);
    idle(1'b1, 40);

    // Runtime rate change on a running channel.
    cfgWrite(1'b1, 0, 'h40);
    idle(1'b1, 40);

    // Asynchronous reset mid-run, observed before any clock edge.
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ce", {29'd0, ce_out}, 32'd0);
    checkOutput("async_rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
    modelReset();
    @(negedge refclk);
    idle(1'b1, 2);
    rst_n = 1'b1;
    idle(1'b1, 10);

    // Randomised traffic: rate writes to any channel (including the
    // out-of-range one) and occasional enable toggles.
    en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) en = !en;
      r = int'($urandom_range(0, 9));
      if (r == 0)      inc = 0;
      else if (r == 1) inc = 255;
      else if (r == 2) inc = 128;
      else             inc = int'($urandom_range(1, 255));
`ifdef CLKEN_GEN_PHASE_EN
      cfg_phase = ACC_W'($urandom_range(0, 255));
`endif
      applyStimulus(en, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), inc);
    end

`ifdef CLKEN_GEN_PHASE_EN
    // Phase-offset channels: ch0 strobes on odd edges, ch1 on even ones.
    idle(1'b0, 2);
    cfg_phase = 8'h80;
    cfgWrite(1'b0, 0, 'h80);
    cfg_phase = 8'h00;
    cfgWrite(1'b0, 1, 'h80);
    idle(1'b0, 3);
    idle(1'b1, 12);
`endif

    idle(1'b1, 2);
    @(negedge refclk);
    @(negedge refclk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
